// File: rtl/bram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// bram_fifo_ctrl
//
// FIFO controller placed in front of a 32-bit true-dual-port BRAM wrapper.
// Port A is the write port and port B is the read port. An incoming
// valid/ready stream is written through port A. Words are prefetched through
// port B, which has a 1-cycle READ_FIRST latency, into a 2-entry output skid
// buffer. The output is a first-word-fall-through valid/ready stream.
//
// Parameters
//   ADDR_BITS   log2 of the BRAM word depth (10 -> 1024 x 32)
//
// Ports
//   CLK         rising-edge clock for all logic and the BRAM
//   RST         asynchronous, active-high reset
//   IN_DATA     write data
//   IN_VALID    IN_DATA valid
//   IN_READY    space available; transfer on IN_VALID & IN_READY at an edge
//   OUT_DATA    head-of-FIFO word
//   OUT_VALID   OUT_DATA valid
//   OUT_READY   consumer takes the word on OUT_VALID & OUT_READY at an edge
//   COUNT       words held: BRAM + in-flight read + output buffer
//   BRAM_ADDRA  {wr_ptr, 5'b0}; 32-bit mode uses address bits [14:5]
//   BRAM_DIA    write data to port A (= IN_DATA)
//   BRAM_WEA    4'hF when a write is accepted this cycle
//   BRAM_ENA    port A enable (= accepted write)
//   BRAM_ADDRB  {rd_ptr, 5'b0}
//   BRAM_DIB    tied to zero
//   BRAM_WEB    tied to zero; port B only reads
//   BRAM_ENB    read issue strobe
//   BRAM_DOB    read data, valid the cycle after BRAM_ENB was sampled high
// ---------------------------------------------------------------------------
module bram_fifo_ctrl #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [31:0]          IN_DATA,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [31:0]          OUT_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [ADDR_BITS+1:0] COUNT,
    output logic [14:0]          BRAM_ADDRA,
    output logic [31:0]          BRAM_DIA,
    output logic [3:0]           BRAM_WEA,
    output logic                 BRAM_ENA,
    output logic [14:0]          BRAM_ADDRB,
    output logic [31:0]          BRAM_DIB,
    output logic [3:0]           BRAM_WEB,
    output logic                 BRAM_ENB,
    input  logic [31:0]          BRAM_DOB
);

    // bcnt value meaning "every BRAM word occupied"
    localparam logic [ADDR_BITS:0] FULL = {1'b1, {ADDR_BITS{1'b0}}};

    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   bcnt;       // words resident in the BRAM
    logic                 inflight;   // a port-B read was issued last cycle
    logic [1:0]           ocnt;       // output skid buffer occupancy, 0..2
    logic [31:0]          obuf_head;  // oldest buffered word, drives OUT_DATA
    logic [31:0]          obuf_tail;  // second buffered word

    logic       wr_accept;
    logic       rd_issue;
    logic       pop;
    logic       push;
    logic [2:0] occ_after;

    // All of these depend only on registered state, so there is no
    // combinational path from OUT_READY to OUT_VALID/OUT_DATA.
    assign IN_READY  = (bcnt != FULL);
    assign OUT_VALID = (ocnt != 2'd0);
    assign OUT_DATA  = obuf_head;

    assign pop  = OUT_VALID & OUT_READY;
    assign push = inflight;

    // Output-side occupancy once this cycle's pop is taken. Issuing only while
    // this is below 2 keeps ocnt + inflight <= 2, so a returning read always
    // finds a free slot in the skid buffer.
    assign occ_after = {1'b0, ocnt} + 3'(inflight) - 3'(pop);

    // IN_READY stays high during reset, so the write strobe is gated by RST
    // to keep port A idle while the controller is held in reset.
    assign wr_accept = IN_VALID & IN_READY & ~RST;
    assign rd_issue  = (bcnt != '0) & (occ_after < 3'd2);

    assign BRAM_DIA = IN_DATA;
    assign BRAM_WEA = wr_accept ? 4'hF : 4'h0;
    assign BRAM_ENA = wr_accept;
    assign BRAM_DIB = 32'h0;
    assign BRAM_WEB = 4'h0;
    assign BRAM_ENB = rd_issue;

    assign COUNT = {1'b0, bcnt}
                 + (ADDR_BITS+2)'(inflight)
                 + (ADDR_BITS+2)'(ocnt);

    // Word address sits at bit 5 of the 15-bit byte-style BRAM address.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path can leave it unassigned and infer a latch.
        BRAM_ADDRA = '0;
        BRAM_ADDRB = '0;
        BRAM_ADDRA[ADDR_BITS+4:5] = wr_ptr;
        BRAM_ADDRB[ADDR_BITS+4:5] = rd_ptr;
    end

    // Control state: pointers, occupancy counters, read-in-flight flag.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            bcnt     <= '0;
            inflight <= 1'b0;
            ocnt     <= 2'd0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + ADDR_BITS'(1);
            if (rd_issue)  rd_ptr <= rd_ptr + ADDR_BITS'(1);

            // A write and a read at the same edge leave bcnt unchanged.
            case ({wr_accept, rd_issue})
                2'b10:   bcnt <= bcnt + (ADDR_BITS+1)'(1);
                2'b01:   bcnt <= bcnt - (ADDR_BITS+1)'(1);
                default: bcnt <= bcnt;
            endcase

            // Reset clears this flag, so a DOB belonging to a read issued
            // before reset is never captured.
            inflight <= rd_issue;
            ocnt     <= ocnt + 2'(push) - 2'(pop);
        end
    end

    // Skid buffer data. Validity is carried entirely by ocnt.
    always_ff @(posedge CLK) begin
        // NOTE: data-only storage is deliberately left out of reset; its
        // contents are never observed while the matching valid state is zero.
        if (pop) begin
            // Shift forward; with one entry left, a simultaneous push lands
            // directly in the head slot.
            obuf_head <= (ocnt == 2'd2) ? obuf_tail : BRAM_DOB;
            if (push) obuf_tail <= BRAM_DOB;
        end else if (push) begin
            if (ocnt == 2'd0) obuf_head <= BRAM_DOB;
            else              obuf_tail <= BRAM_DOB;
        end
    end

endmodule
